// File: rtl/result_reorder_collector.sv
// Collects tagged results that arrive out of order into slots, then drains them
// in tag order (0..N-1) over a valid/ready interface.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | storing results until N distinct tags have been received
// DRAIN   | emitting slots 0..N-1 in order
// DONE    | one-cycle completion pulse, then back to IDLE
module result_reorder_collector #(
    parameter int SLOTS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  expected_cnt,
    input  logic        in_valid,
    input  logic [35:0] in_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  out_tag,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err_dup,
    output logic        err_range,
    output logic        err_unexp
);

    localparam logic [4:0] L_SLOTS = 5'(SLOTS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [4:0]         r_n;
    logic [4:0]         r_cnt;
    logic [3:0]         r_idx;
    logic [SLOTS-1:0]   r_bitmap;
    logic [31:0]        r_slot [SLOTS];
    logic               r_err_dup;
    logic               r_err_range;
    logic               r_err_unexp;

    logic [3:0]         w_tag;
    logic [31:0]        w_payload;
    logic [4:0]         w_n_cap;
    logic               w_start_ok;
    logic               w_in_range;
    logic               w_bit_set;
    logic               w_accept;
    logic               w_is_last;
    logic               w_xfer;

    assign w_tag      = in_data[35:32];
    assign w_payload  = in_data[31:0];
    assign w_n_cap    = (expected_cnt > L_SLOTS) ? L_SLOTS : expected_cnt;
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_in_range = ({1'b0, w_tag} < r_n);
    assign w_bit_set  = r_bitmap[w_tag];
    assign w_accept   = (r_state == S_COLLECT) && in_valid && w_in_range && !w_bit_set;
    assign w_is_last  = (r_state == S_DRAIN) && ({1'b0, r_idx} == (r_n - 5'd1));
    assign w_xfer     = (r_state == S_DRAIN) && out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_n_cap == 5'd0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_accept && ((r_cnt + 5'd1) == r_n)) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_xfer && w_is_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_bitmap    <= '0;
            r_err_dup   <= 1'b0;
            r_err_range <= 1'b0;
            r_err_unexp <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_n         <= w_n_cap;
                r_cnt       <= '0;
                r_idx       <= '0;
                r_bitmap    <= '0;
                r_err_dup   <= 1'b0;
                r_err_range <= 1'b0;
                r_err_unexp <= 1'b0;
            end
            if (w_accept) begin
                r_bitmap[w_tag] <= 1'b1;
                r_cnt           <= r_cnt + 5'd1;
            end
            if ((r_state == S_COLLECT) && in_valid && !w_in_range) begin
                r_err_range <= 1'b1;
            end
            if ((r_state == S_COLLECT) && in_valid && w_in_range && w_bit_set) begin
                r_err_dup <= 1'b1;
            end
            // A strobe coinciding with an accepted start is silently dropped.
            if (in_valid && (((r_state == S_IDLE) && !start) ||
                             (r_state == S_DRAIN) || (r_state == S_DONE))) begin
                r_err_unexp <= 1'b1;
            end
            if (w_xfer && !w_is_last) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    // Payload storage needs no reset; the bitmap tracks which slots are live.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_slot[w_tag] <= w_payload;
        end
    end

    assign out_valid = (r_state == S_DRAIN);
    assign out_tag   = out_valid ? r_idx : 4'd0;
    assign out_data  = out_valid ? r_slot[r_idx] : 32'd0;
    assign out_last  = w_is_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err_dup   = r_err_dup;
    assign err_range = r_err_range;
    assign err_unexp = r_err_unexp;

endmodule

// File: tb/tb_result_reorder_collector.sv
// Directed bench for result_reorder_collector: inputs change and outputs are
// sampled on the falling edge, so each step() crosses exactly one rising edge.
module tb_result_reorder_collector;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  expected_cnt;
    logic        in_valid;
    logic [35:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_tag;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err_dup;
    logic        err_range;
    logic        err_unexp;

    int n_checks = 0;
    int n_errors = 0;

    result_reorder_collector #(.SLOTS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .expected_cnt (expected_cnt),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_tag      (out_tag),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .err_dup      (err_dup),
        .err_range    (err_range),
        .err_unexp    (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic begin_batch(input logic [4:0] cnt);
        start        = 1'b1;
        expected_cnt = cnt;
        step();
        start        = 1'b0;
    endtask

    task automatic send(input logic [3:0] tag, input logic [31:0] payload);
        in_valid = 1'b1;
        in_data  = {tag, payload};
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic expect_out(input string name, input logic [3:0] tag,
                              input logic [31:0] data, input logic last);
        check({name, "_valid"}, out_valid, 1'b1);
        check({name, "_tag"},   out_tag,   tag);
        check({name, "_data"},  out_data,  data);
        check({name, "_last"},  out_last,  last);
    endtask

    task automatic expect_done();
        check("done_valid_low", out_valid, 1'b0);
        check("done_pulse",     done,      1'b1);
        check("done_busy",      busy,      1'b1);
        step();
        check("done_cleared",   done,      1'b0);
        check("idle_busy",      busy,      1'b0);
    endtask

    logic [31:0] exp_data [4];

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        expected_cnt = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        step();
        step();
        check("rst_valid",  out_valid, 1'b0);
        check("rst_tag",    out_tag,   4'd0);
        check("rst_data",   out_data,  32'd0);
        check("rst_last",   out_last,  1'b0);
        check("rst_busy",   busy,      1'b0);
        check("rst_done",   done,      1'b0);
        check("rst_errs",   {err_dup, err_range, err_unexp}, 3'b000);
        rst_n = 1'b1;
        step();

        // In-order reassembly of 3,1,0,2; a strobe alongside start is dropped quietly.
        in_valid = 1'b1;
        in_data  = {4'd0, 32'hEE};
        begin_batch(5'd4);
        in_valid = 1'b0;
        check("s1_busy",       busy,      1'b1);
        check("s1_no_unexp",   err_unexp, 1'b0);
        send(4'd3, 32'hD);
        send(4'd1, 32'hB);
        send(4'd0, 32'hA);
        check("s1_not_yet",    out_valid, 1'b0);
        send(4'd2, 32'hC);
        check("s1_no_dup",     err_dup,   1'b0);
        exp_data = '{32'hA, 32'hB, 32'hC, 32'hD};
        for (int k = 0; k < 4; k++) begin
            expect_out("s1", 4'(k), exp_data[k], k == 3);
            step();
        end
        expect_done();

        // A strobe in IDLE flags err_unexp and persists.
        send(4'd0, 32'h1);
        check("idle_unexp",    err_unexp, 1'b1);
        step();
        check("unexp_sticky",  err_unexp, 1'b1);

        // Duplicate tag keeps the first payload.
        begin_batch(5'd2);
        check("s2_unexp_clr",  err_unexp, 1'b0);
        send(4'd1, 32'h11);
        send(4'd1, 32'h22);
        check("s2_dup",        err_dup,   1'b1);
        check("s2_wait",       out_valid, 1'b0);
        send(4'd0, 32'h33);
        expect_out("s2_t0", 4'd0, 32'h33, 1'b0);
        step();
        expect_out("s2_t1", 4'd1, 32'h11, 1'b1);
        step();
        expect_done();
        check("s2_dup_sticky", err_dup,   1'b1);

        // Out-of-range tag dropped; strobe during DRAIN leaves storage untouched.
        begin_batch(5'd2);
        check("s3_dup_clr",    err_dup,   1'b0);
        send(4'd5, 32'h55);
        check("s3_range",      err_range, 1'b1);
        send(4'd0, 32'h50);
        send(4'd1, 32'h51);
        expect_out("s3_t0", 4'd0, 32'h50, 1'b0);
        send(4'd1, 32'hFF);
        check("s3_unexp",      err_unexp, 1'b1);
        expect_out("s3_t1", 4'd1, 32'h51, 1'b1);
        step();
        expect_done();

        // Backpressure: first element held stable for 5 cycles.
        out_ready = 1'b0;
        begin_batch(5'd3);
        send(4'd2, 32'h72);
        send(4'd0, 32'h70);
        send(4'd1, 32'h71);
        for (int i = 0; i < 5; i++) begin
            expect_out("s4_hold", 4'd0, 32'h70, 1'b0);
            step();
        end
        out_ready = 1'b1;
        exp_data = '{32'h70, 32'h71, 32'h72, 32'h0};
        for (int k = 0; k < 3; k++) begin
            expect_out("s4_xfer", 4'(k), exp_data[k], k == 2);
            step();
        end
        expect_done();

        // Zero-length batch goes straight to DONE.
        begin_batch(5'd0);
        expect_done();

        // expected_cnt above 16 is capped at 16.
        begin_batch(5'd20);
        for (int t = 15; t >= 0; t--) begin
            send(4'(t), 32'h100 + 32'(t));
        end
        check("s5_range_clr",  err_range, 1'b0);
        for (int k = 0; k < 16; k++) begin
            expect_out("s5_cap", 4'(k), 32'h100 + 32'(k), k == 15);
            step();
        end
        expect_done();

        // Reset mid-DRAIN aborts the batch.
        begin_batch(5'd2);
        send(4'd0, 32'h60);
        send(4'd1, 32'h61);
        expect_out("s6_t0", 4'd0, 32'h60, 1'b0);
        step();
        expect_out("s6_t1", 4'd1, 32'h61, 1'b1);
        rst_n = 1'b0;
        step();
        check("s6_valid",      out_valid, 1'b0);
        check("s6_tag",        out_tag,   4'd0);
        check("s6_data",       out_data,  32'd0);
        check("s6_last",       out_last,  1'b0);
        check("s6_busy",       busy,      1'b0);
        check("s6_done",       done,      1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s6_no_done",  done,      1'b0);
            check("s6_no_valid", out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
